mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_if.sv | 19 +
 rtl/mult_div_unit.sv | 140 ++++++++++++++
 tb/tb_mult_div_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the pipeline and the HI/LO multiply-divide unit.
interface mult_div_unit_if;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] Result;

  modport master (output start, operation, a, b, cancel,
                  input  busy, done, divByZero, hi, lo, Result);
  modport slave  (input  start, operation, a, b, cancel,
                  output busy, done, divByZero, hi, lo, Result);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the HI/LO registers.
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write here
// CALC  | 32 shift-add or shift-subtract iterations
// FINAL | sign correction, HI/LO write, done pulse
module mult_div_unit (
  input logic          clk,
  input logic          reset_n,
  mult_div_unit_if.slave bus
);
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opa, opb;
  logic        is_div, neg_q, neg_r, by_zero;
  logic        busy_q, done_q, dbz_q;
  logic [31:0] hi_q, lo_q;

  logic        is_md, op_signed, op_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] msum, shifted, diff;
  logic [63:0] mul_next, div_next, prod_fix;
  logic [31:0] quo_fix, rem_fix, a_raw;

  assign is_md     = (bus.operation[5:2] == 4'b0110);
  assign op_signed = ~bus.operation[0];
  assign op_div    = bus.operation[1];
  assign mag_a     = (op_signed && bus.a[31]) ? -bus.a : bus.a;
  assign mag_b     = (op_signed && bus.b[31]) ? -bus.b : bus.b;

  // acc = {partial product, remaining multiplier} or {remainder, quotient/dividend}
  assign msum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opa} : 33'd0);
  assign mul_next = {msum, acc[31:1]};
  assign shifted  = {acc[63:32], acc[31]};
  assign diff     = shifted - {1'b0, opb};
  assign div_next = diff[32] ? {shifted[31:0], acc[30:0], 1'b0}
                             : {diff[31:0],    acc[30:0], 1'b1};

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
  assign rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
  assign a_raw    = neg_r ? -opa : opa;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opa     <= '0;
      opb     <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            if (is_md) begin
              opa     <= mag_a;
              opb     <= mag_b;
              acc     <= op_div ? {32'd0, mag_a} : {32'd0, mag_b};
              cnt     <= '0;
              is_div  <= op_div;
              neg_q   <= op_signed & (bus.a[31] ^ bus.b[31]);
              neg_r   <= op_signed & bus.a[31];
              by_zero <= op_div & (bus.b == 32'd0);
              busy_q  <= 1'b1;
              state   <= CALC;
            end else if (bus.operation == OP_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.operation == OP_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        CALC: begin
          if (bus.cancel) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            acc <= is_div ? div_next : mul_next;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FINAL;
          end
        end
        FINAL: begin
          if (!bus.cancel) begin
            if (!is_div) begin
              hi_q <= prod_fix[63:32];
              lo_q <= prod_fix[31:0];
            end else if (by_zero) begin
              hi_q <= a_raw;
              lo_q <= 32'hFFFF_FFFF;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
            done_q <= 1'b1;
            dbz_q  <= by_zero;
          end
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.Result = 32'd0;
    if (bus.operation == OP_MFHI) bus.Result = hi_q;
    else if (bus.operation == OP_MFLO) bus.Result = lo_q;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed and randomized checks of mult_div_unit against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  logic clk;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit_if bus ();
  mult_div_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void model(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint sp, sq, sr;
    longint unsigned up;
    int sa, sb;
    sa = av; sb = bv; z = 1'b0; h = m_hi; l = m_lo;
    if ((op == OP_DIV || op == OP_DIVU) && bv == 32'd0) begin
      h = av; l = 32'hFFFF_FFFF; z = 1'b1;
    end else begin
      case (op)
        OP_MULT:  begin sp = longint'(sa) * longint'(sb); h = sp[63:32]; l = sp[31:0]; end
        OP_MULTU: begin up = {32'd0, av} * {32'd0, bv}; h = up[63:32]; l = up[31:0]; end
        OP_DIV: begin
          sq = longint'(sa) / longint'(sb);
          sr = longint'(sa) % longint'(sb);
          l = sq[31:0]; h = sr[31:0];
        end
        OP_DIVU: begin l = av / bv; h = av % bv; end
        default: ;
      endcase
    end
  endfunction

  task automatic drive_start(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    bus.start = 1'b1; bus.operation = op; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int n, output logic busy_pre);
    n = 0; busy_pre = 1'b0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) break;
      busy_pre = bus.busy;
    end
  endtask

  task automatic do_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv, input string tag);
    logic [31:0] eh, el;
    logic ez, bp;
    int n;
    model(op, av, bv, eh, el, ez);
    drive_start(op, av, bv);
    chk({tag, "_busy_start"}, bus.busy, 1);
    chk({tag, "_result_zero"}, bus.Result, 0);
    wait_done(n, bp);
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_busy_e32"}, bp, 1);
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_hi"}, bus.hi, eh);
    chk({tag, "_lo"}, bus.lo, el);
    chk({tag, "_dbz"}, bus.divByZero, ez);
    m_hi = eh; m_lo = el;
    @(posedge clk); #1;
    chk({tag, "_done_drop"}, bus.done, 0);
    chk({tag, "_dbz_drop"}, bus.divByZero, 0);
  endtask

  initial begin
    logic [5:0] ops [4];
    logic [31:0] ra, rb, eh, el;
    logic ez, bp;
    int n, dones;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
    m_hi = 0; m_lo = 0;
    bus.start = 0; bus.operation = OP_MFHI; bus.a = 0; bus.b = 0; bus.cancel = 0;

    reset_n = 1'b0;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_dbz", bus.divByZero, 0);
    chk("rst_hi", bus.hi, 0);
    chk("rst_lo", bus.lo, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg3x5");
    chk("mult_neg3x5_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_neg3x5_lo_const", bus.lo, 32'hFFFF_FFF1);
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi_const", bus.hi, 32'hFFFF_FFFE);
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg7_2");
    chk("div_neg7_2_lo_const", bus.lo, 32'hFFFF_FFFD);
    do_op(OP_DIVU,  32'd7,         32'd0,         "divu_by0");
    do_op(OP_DIV,   32'hFFFF_FFF9, 32'd0,         "div_by0");
    do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lo_const", bus.lo, 32'h8000_0000);
    do_op(OP_DIV,   32'd100,       32'hFFFF_FFF9, "div_pos_neg");
    do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minmin");

    for (int i = 0; i < 12; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(1, 300));
      do_op(ops[$urandom_range(0, 3)], ra, rb, $sformatf("rand%0d", i));
    end

    // MTHI/MTLO and reads during a busy operation
    drive_start(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_busy", bus.busy, 0);
    m_hi = 32'h1234;
    drive_start(OP_MTLO, 32'h5678, 32'd0);
    m_lo = 32'h5678;
    bus.operation = OP_MFHI; #1;
    chk("mfhi_read", bus.Result, 32'h1234);
    bus.operation = OP_MFLO; #1;
    chk("mflo_read", bus.Result, 32'h5678);
    chk("mtlo_no_done", bus.done, 0);
    model(OP_MULT, 32'd7, 32'hFFFF_FFF7, eh, el, ez);
    drive_start(OP_MULT, 32'd7, 32'hFFFF_FFF7);
    repeat (9) begin @(posedge clk); #1; end
    bus.operation = OP_MFHI; #1;
    chk("mfhi_during_busy", bus.Result, 32'h1234);
    bus.operation = OP_MFLO; #1;
    chk("mflo_during_busy", bus.Result, 32'h5678);
    wait_done(n, bp);
    chk("mult_after_mthi_latency", n, 24);
    chk("mult_after_mthi_hi", bus.hi, eh);
    chk("mult_after_mthi_lo", bus.lo, el);
    m_hi = eh; m_lo = el;

    // second start during a divide is dropped
    model(OP_DIVU, 32'd100, 32'd7, eh, el, ez);
    drive_start(OP_DIVU, 32'd100, 32'd7);
    repeat (3) begin @(posedge clk); #1; end
    drive_start(OP_MULTU, 32'd3, 32'd3);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("restart_done_count", dones, 1);
    chk("restart_hi", bus.hi, eh);
    chk("restart_lo", bus.lo, el);
    m_hi = eh; m_lo = el;

    // unknown function code is ignored
    drive_start(6'b000000, 32'hDEAD, 32'd1);
    chk("badop_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("badop_done", bus.done, 0);
    chk("badop_hi", bus.hi, m_hi);

    // cancel beats start in IDLE
    @(negedge clk);
    bus.cancel = 1'b1; bus.start = 1'b1; bus.operation = OP_MULT; bus.a = 3; bus.b = 4;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("cancel_start_busy", bus.busy, 0);
    @(negedge clk);
    bus.cancel = 1'b1; bus.start = 1'b1; bus.operation = OP_MTHI; bus.a = 32'hBEEF;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.cancel = 1'b0;
    chk("cancel_mthi_hi", bus.hi, m_hi);

    // asynchronous reset mid-multiply
    drive_start(OP_MULT, 32'd5, 32'd6);
    repeat (9) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_hi", bus.hi, 0);
    chk("midrst_lo", bus.lo, 0);
    chk("midrst_done", bus.done, 0);
    m_hi = 0; m_lo = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    do_op(OP_MULTU, 32'd12345, 32'd678, "post_rst");

    // cancel mid-divide
    drive_start(OP_DIV, 32'hFFFF_FF9C, 32'd3);
    repeat (19) begin @(posedge clk); #1; end
    @(negedge clk) bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cancel_busy", bus.busy, 0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done) dones++;
    end
    chk("cancel_done_count", dones, 0);
    chk("cancel_hi", bus.hi, m_hi);
    chk("cancel_lo", bus.lo, m_lo);
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd3, "post_cancel");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
